spill_trigger_gate: RTL
=======================

// Module: spill_trigger_gate
// PURPOSE
//  Downstream consumer of the live/tena window generator. Gates raw trigger pulses with the tena
//  window, deadtime and a downstream busy line, and numbers each accepted trigger within the spill.
//  Counts accepted and rejected triggers and live cycles per spill. At every live falling edge it
//  presents a per-spill summary record on a valid/ready port for the readout/monitor logic.
// PARAMETERS
//  CNT_W     32  width of trigger-number, accept, reject and live-cycle counters
//  SPILL_W   16  width of spill number
//  DEADTIME  4   cycles after an accepted trigger during which new triggers are rejected (>=1)
// PORTS
//  clk              in   1        system clock
//  rst_n            in   1        reset, asynchronous assert, active-low
//  in_live          in   1        live window from the window generator
//  in_tena          in   1        trigger-enable window (falls before in_live)
//  in_trig          in   1        raw trigger level, synchronous to clk; a rising edge is one request
//  in_busy          in   1        downstream busy; a request is rejected while high
//  out_trig         out  1        one-cycle accepted-trigger strobe
//  out_trig_num     out  CNT_W    index of the accepted trigger within the spill, valid with out_trig
//  out_spill_active out  1        high in RUN state
//  sum_valid        out  1        summary record available
//  sum_ready        in   1        summary consumed when sum_valid & sum_ready
//  sum_spill        out  SPILL_W  spill number, first spill = 1
//  sum_acc          out  CNT_W    accepted triggers in the spill
//  sum_rej          out  CNT_W    rejected triggers while in_live=1
//  sum_live_cyc     out  CNT_W    cycles with in_live=1
//  sum_ovf          out  1        sticky: an unread summary was overwritten; clears on handshake
// BEHAVIOUR
//  Reset: all outputs 0; spill number, counters, deadtime counter and trig_q cleared; FSM=IDLE.
//  Edge: req = in_trig & ~trig_q (trig_q = in_trig delayed one clk).
//  FSM: IDLE -(in_live=1)-> RUN; RUN -(in_live=0)-> CLOSE; CLOSE -> IDLE, or RUN if in_live=1.
//   Entering RUN (the cycle in_live is sampled 1 in IDLE/CLOSE): spill_num+1 (wraps); acc, rej,
//   live_cyc and trig number cleared. A req in that same cycle is evaluated after the clear.
//  Accept when req & in_live & in_tena & ~in_busy & dead_cnt==0:
//   out_trig=1 on the next cycle, out_trig_num = acc before increment (0,1,2,...); acc+1;
//   dead_cnt loaded with DEADTIME and decrements to 0 (it keeps counting across spill edges).
//  Reject: req & in_live & not accepted -> rej+1. A req with in_live=0 is ignored and not counted.
//  live_cyc+1 on every cycle in_live=1. acc, rej and live_cyc saturate at all-ones.
//  CLOSE: the sum_* registers load spill_num/acc/rej/live_cyc; sum_valid=1. If sum_valid was
//   already 1 with no handshake in that cycle, the old record is overwritten and sum_ovf=1.
//   A handshake in the CLOSE cycle completes and the new record loads with no overflow.
//  sum_valid stays high and sum_* stay stable until the handshake; sum_valid drops the cycle after.
//  out_spill_active follows the FSM state (registered; high in RUN only).
//  Reset mid-spill: everything clears immediately; no summary is produced for the aborted spill.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/RUN/CLOSE) and the summary record layout/widths,
//   because the readout packer decodes the record.
//  One sub-module: sat_counter (CNT_W, clear, increment, saturate). Instantiate it for acc, rej
//   and live_cyc.
// TESTING
//  1 Reset released with all inputs 0 -> all outputs 0, no sum_valid for 100 cycles.
//  2 live=tena=1 for 200 cycles, trigger edges at cycles 10, 30, 50 -> three out_trig with nums
//    0, 1, 2. Live falls -> sum_valid with spill=1, acc=3, rej=0, live_cyc=200.
//  3 live=1, tena=0 with 2 trigger edges; 1 edge with live=0 -> no out_trig; summary rej=2, acc=0.
//  4 DEADTIME=4: edges 2 cycles apart, then 6 cycles later -> first accepted, second rejected,
//    third accepted; busy=1 on a fourth edge -> rejected.
//  5 sum_ready=0 over two spills -> second record (spill=2) shown, sum_ovf=1; handshake clears
//    sum_valid and sum_ovf.
//  6 rst_n low mid-RUN after 2 accepts -> outputs 0 at once; next spill summary has spill=1, acc
//    counts only the new spill.

Source files
------------

// File: rtl/spill_trigger_gate_pkg.sv
// Shared definitions for the spill trigger gate and the readout packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the per-spill summary record layout, so the
// readout packer decodes the record with the same field order and widths.
package spill_trigger_gate_pkg;

  localparam int STG_CNT_W    = 32;
  localparam int STG_SPILL_W  = 16;
  localparam int STG_DEADTIME = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLOSE = 2'd2
  } stg_state_e;

  // Summary record as the readout packer sees it, MSB first.
  typedef struct packed {
    logic [STG_SPILL_W-1:0] spill;
    logic [STG_CNT_W-1:0]   acc;
    logic [STG_CNT_W-1:0]   rej;
    logic [STG_CNT_W-1:0]   live_cyc;
    logic                   ovf;
  } sum_rec_t;

endpackage

// File: rtl/spill_trigger_gate_sat_counter.sv
// Saturating up-counter with a same-cycle clear-then-increment.
// Latency: count visible one cycle after inc_i.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst_n (async active-low), clr_i (restart count), inc_i (count
// this cycle), cnt_o (current count).
module spill_trigger_gate_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A clear and an increment in the same cycle yield 1: the event belongs to
  // the new count window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spill_trigger_gate.sv
// Gates raw triggers with tena/deadtime/busy, numbers them per spill, emits per-spill summary.
// Latency: out_trig 1 cycle after the request edge; summary 2 cycles after in_live falls.
// Backpressure: summary holds until sum_ready; an unread record is overwritten and flagged sum_ovf.
//
// Ports: clk, rst_n (async active-low); in_live/in_tena/in_trig/in_busy from the
// window generator and downstream; out_trig/out_trig_num accepted-trigger strobe
// and index; out_spill_active high in RUN; sum_* valid/ready summary record.
module spill_trigger_gate
  import spill_trigger_gate_pkg::*;
#(
  parameter int CNT_W    = STG_CNT_W,
  parameter int SPILL_W  = STG_SPILL_W,
  parameter int DEADTIME = STG_DEADTIME
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_live,
  input  logic               in_tena,
  input  logic               in_trig,
  input  logic               in_busy,
  output logic               out_trig,
  output logic [CNT_W-1:0]   out_trig_num,
  output logic               out_spill_active,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [SPILL_W-1:0] sum_spill,
  output logic [CNT_W-1:0]   sum_acc,
  output logic [CNT_W-1:0]   sum_rej,
  output logic [CNT_W-1:0]   sum_live_cyc,
  output logic               sum_ovf
);

  localparam int DEAD_W = $clog2(DEADTIME + 1);

  stg_state_e state_q, state_d;

  logic               trig_q;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [SPILL_W-1:0] spill_num_q, spill_num_d;
  logic               out_trig_q, out_trig_d;
  logic [CNT_W-1:0]   out_num_q, out_num_d;
  logic               active_q, active_d;

  logic               sum_vld_q, sum_vld_d;
  logic               sum_ovf_q, sum_ovf_d;
  logic [SPILL_W-1:0] sum_spill_q, sum_spill_d;
  logic [CNT_W-1:0]   sum_acc_q, sum_acc_d;
  logic [CNT_W-1:0]   sum_rej_q, sum_rej_d;
  logic [CNT_W-1:0]   sum_live_q, sum_live_d;

  logic             enter_run;
  logic             close_load;
  logic             req;
  logic             accept;
  logic             reject;
  logic             sum_hs;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] rej_cnt;
  logic [CNT_W-1:0] live_cnt;
  logic [CNT_W-1:0] acc_now;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = in_live ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = in_live ? ST_RUN : ST_CLOSE;
      ST_CLOSE: state_d = in_live ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    enter_run  = in_live && (state_q != ST_RUN);
    close_load = (state_q == ST_CLOSE);
    active_d   = (state_d == ST_RUN);
  end

  // ---------------- trigger gating ----------------
  assign req    = in_trig & ~trig_q;
  assign accept = req & in_live & in_tena & ~in_busy & (dead_cnt_q == '0);
  assign reject = req & in_live & ~accept;
  assign sum_hs = sum_vld_q & sum_ready;

  // The trigger number of a request arriving on the spill's first cycle must
  // see the cleared count, not the previous spill's total.
  assign acc_now = enter_run ? '0 : acc_cnt;

  always_comb begin
    spill_num_d = enter_run ? spill_num_q + SPILL_W'(1) : spill_num_q;
    out_trig_d  = accept;
    out_num_d   = accept ? acc_now : out_num_q;

    // Deadtime is independent of spill boundaries.
    dead_cnt_d = dead_cnt_q;
    if (accept) begin
      dead_cnt_d = DEAD_W'(DEADTIME);
    end else if (dead_cnt_q != '0) begin
      dead_cnt_d = dead_cnt_q - DEAD_W'(1);
    end
  end

  spill_trigger_gate_sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (enter_run),
    .inc_i (accept),
    .cnt_o (acc_cnt)
  );

  spill_trigger_gate_sat_counter #(.W(CNT_W)) u_rej_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (enter_run),
    .inc_i (reject),
    .cnt_o (rej_cnt)
  );

  spill_trigger_gate_sat_counter #(.W(CNT_W)) u_live_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (enter_run),
    .inc_i (in_live),
    .cnt_o (live_cnt)
  );

  // ---------------- summary record ----------------
  // In CLOSE the counters still hold the finished spill: even if in_live is
  // back this cycle, the clear lands on the same edge as the load.
  always_comb begin
    sum_vld_d   = sum_vld_q;
    sum_ovf_d   = sum_ovf_q;
    sum_spill_d = sum_spill_q;
    sum_acc_d   = sum_acc_q;
    sum_rej_d   = sum_rej_q;
    sum_live_d  = sum_live_q;
    if (close_load) begin
      sum_vld_d   = 1'b1;
      // Overwrite only counts when the old record was not taken this cycle.
      sum_ovf_d   = sum_vld_q & ~sum_ready;
      sum_spill_d = spill_num_q;
      sum_acc_d   = acc_cnt;
      sum_rej_d   = rej_cnt;
      sum_live_d  = live_cnt;
    end else if (sum_hs) begin
      sum_vld_d = 1'b0;
      sum_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      dead_cnt_q  <= '0;
      spill_num_q <= '0;
      out_trig_q  <= 1'b0;
      out_num_q   <= '0;
      active_q    <= 1'b0;
      sum_vld_q   <= 1'b0;
      sum_ovf_q   <= 1'b0;
      sum_spill_q <= '0;
      sum_acc_q   <= '0;
      sum_rej_q   <= '0;
      sum_live_q  <= '0;
    end else begin
      trig_q      <= in_trig;
      dead_cnt_q  <= dead_cnt_d;
      spill_num_q <= spill_num_d;
      out_trig_q  <= out_trig_d;
      out_num_q   <= out_num_d;
      active_q    <= active_d;
      sum_vld_q   <= sum_vld_d;
      sum_ovf_q   <= sum_ovf_d;
      sum_spill_q <= sum_spill_d;
      sum_acc_q   <= sum_acc_d;
      sum_rej_q   <= sum_rej_d;
      sum_live_q  <= sum_live_d;
    end
  end

  assign out_trig         = out_trig_q;
  assign out_trig_num     = out_num_q;
  assign out_spill_active = active_q;
  assign sum_valid        = sum_vld_q;
  assign sum_spill        = sum_spill_q;
  assign sum_acc          = sum_acc_q;
  assign sum_rej          = sum_rej_q;
  assign sum_live_cyc     = sum_live_q;
  assign sum_ovf          = sum_ovf_q;

endmodule
